sys_reset_sequencer: RTL
========================

Name: sys_reset_sequencer

Overview:
Controls power-up and recovery resets for the system-manager subsystem. It waits for device init to finish and for the TOD/PTP IOPLL lock to be stable. It then releases the core reset, the DMA port0 rx reset and the DMA port1 rx reset in a staggered sequence. After the sequence completes it serves per-port software reset requests and restarts the whole sequence if PLL lock is lost. It sits between the sys_manager clock/reset outputs and the DMA subsystem reset inputs.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before release (≥2)
STAGGER_CYCLES, 16, cycles between successive reset releases (≥1)
PORT_RST_CYCLES, 32, width of a software-requested port reset (≥1)
CNT_W, 16, internal counter width; must hold the max of the three above

Ports:
clk_clk  in  1  single clock for the block (100 MHz domain)
reset_reset_n  in  1  asynchronous, active-low reset
ninit_done  in  1  device init flag, 1 = still initialising; asynchronous
pll_locked  in  1  IOPLL lock; asynchronous
sw_port_rst_req  in  2  one-cycle request pulses; bit0 = DMA port0, bit1 = DMA port1
sw_port_rst_ack  out  2  one-cycle completion pulses, per port
core_reset_n  out  1  core reset, active-low
dma_port0_reset_n  out  1  DMA port0 rx reset, active-low
dma_port1_reset_n  out  1  DMA port1 rx reset, active-low
ready  out  1  high when the sequence is complete and the state is RUN
seq_state  out  3  current state encoding (debug)
lock_loss_cnt  out  8  count of lock losses, saturates at 255

Behaviour:
- Reset values (clock and reset exactly as decided: one clock `clk_clk`; reset `reset_reset_n` is asynchronous and active-low):
  - All reset outputs = 0.
  - ready = 0, ack = 0, lock_loss_cnt = 0, pending = 0, counter = 0.
  - State = WAIT_INIT (0).
- Synchronisers: ninit_done and pll_locked each pass through a 2-flop synchroniser (ninit_s, lock_s); the ninit_done synchroniser resets to 1 and the pll_locked synchroniser resets to 0. All outputs are registered.
- State encodings: WAIT_INIT=0, WAIT_LOCK=1, REL_CORE=2, REL_P0=3, REL_P1=4, RUN=5, PORT_RST=6.
- WAIT_INIT: go to WAIT_LOCK when ninit_s=0. After leaving this state, ninit_done is ignored.
- WAIT_LOCK:
  - The counter increments while lock_s=1 and clears when lock_s=0.
  - When lock_s=1 and counter=LOCK_STABLE_CYCLES-1, go to REL_CORE, clear the counter, and set core_reset_n=1 on that same edge.
  - Resulting timing: core_reset_n rises LOCK_STABLE_CYCLES+2 cycles after pll_locked rises.
- REL_CORE: after STAGGER_CYCLES cycles, set dma_port0_reset_n=1 and go to REL_P0.
- REL_P0: after STAGGER_CYCLES cycles, set dma_port1_reset_n=1 and go to REL_P1.
- REL_P1: after STAGGER_CYCLES cycles, set ready=1 and go to RUN.
- Request latching:
  - Set pending[i] whenever sw_port_rst_req[i]=1, in any state other than reset.
  - Requests arriving during sequencing are held and served once the block reaches RUN.
- RUN:
  - If pending≠0, select the lowest set bit i, clear pending[i], drive port i's reset_n=0, and go to PORT_RST.
  - ready stays 1 in RUN and PORT_RST.
- PORT_RST:
  - Hold port i in reset for exactly PORT_RST_CYCLES cycles.
  - Then release it, pulse sw_port_rst_ack[i] for 1 cycle on the same edge, and return to RUN.
  - The other port and core_reset_n are untouched.
  - A new request for port i that arrives during its own PORT_RST is re-latched and served again afterwards.
  - If both ports are pending, port0 is served first, then port1. There is at least one RUN cycle between the two.
- Simultaneous request and ack: a request for port i that arrives on the same cycle as its ack sets pending[i].
- Lock loss, in any state ≥ REL_CORE:
  - On lock_s=0, next edge: all three reset_n = 0, ready=0, counter=0, state=WAIT_LOCK.
  - lock_loss_cnt increments, saturating at 255.
  - Every set pending bit, and the port currently in PORT_RST, gets an ack pulse and is cleared.
  - Lock loss takes priority over all other transitions.
- Lock loss in WAIT_LOCK only clears the counter; it does not increment lock_loss_cnt.
- Asynchronous reset assertion mid-sequence immediately forces all reset values.

Test Plan (LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=4, PORT_RST_CYCLES=6):
1. Power-up: release reset, ninit_done 1→0 at cycle 5, pll_locked=1 from cycle 10 → core_reset_n rises at cycle 20, port0 at 24, port1 at 28, ready at 32; seq_state=5.
2. Unstable lock: toggle pll_locked low for 1 cycle at the 5th locked cycle → counter restarts; core_reset_n rises 10 cycles after the re-lock; lock_loss_cnt=0.
3. Single soft reset: in RUN, pulse sw_port_rst_req=01 → dma_port0_reset_n low 6 cycles, one ack=01 pulse on release; port1 and core stay high.
4. Dual request: pulse req=11 in one cycle → port0 reset for 6 cycles with ack 01, then port1 reset for 6 cycles with ack 10; ready stays 1 throughout.
5. Lock loss during PORT_RST of port1 with port0 pending → all resets low next cycle, ack=11, lock_loss_cnt=1, sequence restarts and completes.
6. Async reset asserted during REL_P0 → outputs 0 immediately, without waiting for a clock edge; state=0.

Source files
------------

// File: rtl/sys_reset_sequencer.sv
// Staged reset release for the system-manager subsystem: waits for init and stable
// PLL lock, releases core then DMA port resets, then serves per-port soft resets.
module sys_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGGER_CYCLES     = 16,
  parameter int unsigned PORT_RST_CYCLES    = 32,
  parameter int unsigned CNT_W              = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       ninit_done,
  input  logic       pll_locked,
  input  logic [1:0] sw_port_rst_req,
  output logic [1:0] sw_port_rst_ack,
  output logic       core_reset_n,
  output logic       dma_port0_reset_n,
  output logic       dma_port1_reset_n,
  output logic       ready,
  output logic [2:0] seq_state,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned LOSS_W = 8;
  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  PORT_LAST = CNT_W'(PORT_RST_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = '1;

  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    WAIT_LOCK = 3'd1,
    REL_CORE  = 3'd2,
    REL_P0    = 3'd3,
    REL_P1    = 3'd4,
    RUN       = 3'd5,
    PORT_RST  = 3'd6
  } state_t;

  logic ninit_meta, ninit_s, lock_meta, lock_s;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         pending_q, pending_d;
  logic               cur_q, cur_d;
  logic               core_q, core_d, p0_q, p0_d, p1_q, p1_d;
  logic               ready_q, ready_d;
  logic [1:0]         ack_q, ack_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               lock_lost;

  // Two-flop synchronisers; ninit resets to "still initialising"
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ninit_meta <= 1'b1;
      ninit_s    <= 1'b1;
      lock_meta  <= 1'b0;
      lock_s     <= 1'b0;
    end else begin
      ninit_meta <= ninit_done;
      ninit_s    <= ninit_meta;
      lock_meta  <= pll_locked;
      lock_s     <= lock_meta;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= WAIT_INIT;
      cnt_q     <= '0;
      pending_q <= '0;
      cur_q     <= 1'b0;
      core_q    <= 1'b0;
      p0_q      <= 1'b0;
      p1_q      <= 1'b0;
      ready_q   <= 1'b0;
      ack_q     <= '0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      cur_q     <= cur_d;
      core_q    <= core_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      loss_q    <= loss_d;
    end
  end

  assign lock_lost = !lock_s && (state_q inside {REL_CORE, REL_P0, REL_P1, RUN, PORT_RST});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | sw_port_rst_req;
    cur_d     = cur_q;
    core_d    = core_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    ready_d   = ready_q;
    ack_d     = '0;
    loss_d    = loss_q;

    // Lock loss overrides everything: flush outstanding work and restart
    if (lock_lost) begin
      state_d   = WAIT_LOCK;
      cnt_d     = '0;
      core_d    = 1'b0;
      p0_d      = 1'b0;
      p1_d      = 1'b0;
      ready_d   = 1'b0;
      ack_d     = pending_q | ((state_q == PORT_RST) ? {cur_q, !cur_q} : 2'b00);
      pending_d = sw_port_rst_req;
      if (loss_q != LOSS_MAX) loss_d = loss_q + LOSS_W'(1);
    end else begin
      case (state_q)
        WAIT_INIT: if (!ninit_s) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = REL_CORE;
            cnt_d   = '0;
            core_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        REL_CORE, REL_P0, REL_P1: begin
          if (cnt_q == STAG_LAST) begin
            cnt_d = '0;
            if (state_q == REL_CORE) begin
              p0_d    = 1'b1;
              state_d = REL_P0;
            end else if (state_q == REL_P0) begin
              p1_d    = 1'b1;
              state_d = REL_P1;
            end else begin
              ready_d = 1'b1;
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_d = '0;
          if (pending_q[0]) begin
            cur_d        = 1'b0;
            pending_d[0] = sw_port_rst_req[0];
            p0_d         = 1'b0;
            state_d      = PORT_RST;
          end else if (pending_q[1]) begin
            cur_d        = 1'b1;
            pending_d[1] = sw_port_rst_req[1];
            p1_d         = 1'b0;
            state_d      = PORT_RST;
          end
        end
        PORT_RST: begin
          if (cnt_q == PORT_LAST) begin
            cnt_d   = '0;
            state_d = RUN;
            if (cur_q) begin
              p1_d  = 1'b1;
              ack_d = 2'b10;
            end else begin
              p0_d  = 1'b1;
              ack_d = 2'b01;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = WAIT_INIT;
      endcase
    end
  end

  assign sw_port_rst_ack   = ack_q;
  assign core_reset_n      = core_q;
  assign dma_port0_reset_n = p0_q;
  assign dma_port1_reset_n = p1_q;
  assign ready             = ready_q;
  assign seq_state         = state_q;
  assign lock_loss_cnt     = loss_q;

endmodule
